// File: rtl/ledframe_tx.sv
// APA102-style frame serializer: shifts one 32-bit START/LED/END word MSB-first on SCK/MOSI.
// Define LEDFRAME_CLAMP_EN to clamp LED color bytes to MAX_COLOR at load time.
module ledframe_tx #(
  parameter int unsigned HALF_PERIOD       = 2,
  parameter logic [4:0]  GLOBAL_BRIGHTNESS = 5'd31,
  parameter logic [7:0]  MAX_COLOR         = 8'd100
) (
  input  logic       ledframe_clk,
  input  logic       ledframe_reset,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
  input  logic [1:0] type_input,
  input  logic       ledframe_start,
  output logic       ledframe_busy,
  output logic       mosi,
  output logic       sck
);

`ifdef LEDFRAME_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  phase_cnt_q, phase_cnt_d;
  logic        busy_q, busy_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic [7:0]  blue_eff, green_eff, red_eff;
  logic [31:0] frame_word;

  always_comb begin
    blue_eff  = blue_input;
    green_eff = green_input;
    red_eff   = red_input;
    if (CLAMP_EN) begin
      if (blue_input  > MAX_COLOR) blue_eff  = MAX_COLOR;
      if (green_input > MAX_COLOR) green_eff = MAX_COLOR;
      if (red_input   > MAX_COLOR) red_eff   = MAX_COLOR;
    end
  end

  always_comb begin
    case (type_input)
      2'd1:    frame_word = {3'b111, GLOBAL_BRIGHTNESS, blue_eff, green_eff, red_eff};
      2'd2:    frame_word = '1;
      default: frame_word = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    phase_cnt_d = phase_cnt_q;
    busy_d      = busy_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (ledframe_start && (type_input != 2'd3)) begin
          shift_d     = frame_word;
          bit_cnt_d   = 5'd31;
          phase_cnt_d = '0;
          mosi_d      = frame_word[31];
          busy_d      = 1'b1;
          state_d     = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_cnt_q == PHASE_LAST) begin
          sck_d       = 1'b1;
          phase_cnt_d = '0;
          state_d     = SHIFT_HI;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (phase_cnt_q == PHASE_LAST) begin
          // MOSI only moves together with the SCK falling edge.
          sck_d       = 1'b0;
          phase_cnt_d = '0;
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[30:0], 1'b0};
            mosi_d    = shift_q[30];
            bit_cnt_d = bit_cnt_q - 5'd1;
            state_d   = SHIFT_LO;
          end else begin
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ledframe_clk or posedge ledframe_reset) begin
    if (ledframe_reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      phase_cnt_q <= '0;
      busy_q      <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      busy_q      <= busy_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
    end
  end

  assign ledframe_busy = busy_q;
  assign sck           = sck_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_ledframe_tx.sv
// Bench for ledframe_tx: frames captured on SCK rises are compared with words built from the frame rules.
module tb_ledframe_tx;

  localparam int unsigned HP = 2;
  localparam logic [7:0]  MAXC = 8'd100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] blue = '0, green = '0, red = '0;
  logic [1:0] type_in = '0;
  logic       start = 1'b0;
  logic       busy, mosi, sck;

  int unsigned checks = 0;
  int unsigned failures = 0;

  ledframe_tx #(.HALF_PERIOD(HP), .GLOBAL_BRIGHTNESS(5'd31), .MAX_COLOR(MAXC)) dut (
    .ledframe_clk(clk),
    .ledframe_reset(rst),
    .blue_input(blue),
    .green_input(green),
    .red_input(red),
    .type_input(type_in),
    .ledframe_start(start),
    .ledframe_busy(busy),
    .mosi(mosi),
    .sck(sck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lim(input logic [7:0] x);
`ifdef LEDFRAME_CLAMP_EN
    return (x > MAXC) ? MAXC : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [1:0] t, input logic [7:0] b, g, r);
    if (t == 2'd0) return 32'h0000_0000;
    if (t == 2'd2) return 32'hFFFF_FFFF;
    return {3'b111, 5'd31, lim(b), lim(g), lim(r)};
  endfunction

  // Requests one frame, then watches it cycle by cycle until busy drops (or abort on reset).
  task automatic run_frame(input logic [1:0] t, input logic [7:0] b, g, r,
                           input int unsigned noise_at, input int unsigned abort_at,
                           output logic [31:0] word, output int unsigned busy_cycles,
                           output int unsigned rises, output bit stable_ok);
    int unsigned guard;
    logic prev_sck, last_mosi;
    type_in = t; blue = b; green = g; red = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_latency", {31'd0, busy}, 32'd1);
    word = '0; busy_cycles = 0; rises = 0; stable_ok = 1'b1;
    prev_sck = 1'b0; last_mosi = 1'b0; guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      busy_cycles++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        word = {word[30:0], mosi};
        rises++;
        last_mosi = mosi;
      end else if (sck === 1'b1 && mosi !== last_mosi) begin
        stable_ok = 1'b0;
      end
      prev_sck = sck;
      if (noise_at != 0 && busy_cycles == noise_at) begin
        start = 1'b1; type_in = 2'($urandom_range(0, 3));
        blue = 8'($urandom); green = 8'($urandom); red = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (abort_at != 0 && rises == abort_at && sck === 1'b1) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sck", {31'd0, sck}, 32'd0);
        check("abort_mosi", {31'd0, mosi}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
  endtask

  task automatic full_frame(input string tag, input logic [1:0] t, input logic [7:0] b, g, r,
                            input int unsigned noise_at);
    logic [31:0] w;
    int unsigned bc, rs;
    bit st;
    logic [31:0] exp;
    exp = model_word(t, b, g, r);
    run_frame(t, b, g, r, noise_at, 0, w, bc, rs, st);
    check({tag, "_word"}, w, exp);
    check({tag, "_busy_cycles"}, bc, 64 * HP);
    check({tag, "_rises"}, rs, 32);
    check({tag, "_mosi_stable"}, {31'd0, st}, 32'd1);
    check({tag, "_idle_sck"}, {31'd0, sck}, 32'd0);
    check({tag, "_idle_mosi"}, {31'd0, mosi}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int unsigned bc, rs;
    bit st;

    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sck", {31'd0, sck}, 32'd0);
    check("reset_mosi", {31'd0, mosi}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    full_frame("start", 2'd0, 8'hAA, 8'h55, 8'hFF, 0);
    @(posedge clk); #1;
    full_frame("led123456", 2'd1, 8'h12, 8'h34, 8'h56, 0);
    @(posedge clk); #1;

    // END followed by START requested in the first busy-low cycle.
    full_frame("end", 2'd2, 8'h00, 8'h00, 8'h00, 0);
    full_frame("b2b_start", 2'd0, 8'hFF, 8'hFF, 8'hFF, 0);

    full_frame("noise_led", 2'd1, 8'h81, 8'h7E, 8'h03, 40);
    @(posedge clk); #1;

    type_in = 2'd3; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("type3_busy", {31'd0, busy}, 32'd0);
      check("type3_sck", {31'd0, sck}, 32'd0);
    end
    start = 1'b0;
    @(posedge clk); #1;

    run_frame(2'd2, 8'h00, 8'h00, 8'h00, 0, 10, w, bc, rs, st);
    check("abort_rises", rs, 10);
    @(posedge clk); #1;
    full_frame("post_reset_start", 2'd0, 8'h11, 8'h22, 8'h33, 0);
    @(posedge clk); #1;

    full_frame("clamp_led", 2'd1, 8'd200, 8'd100, 8'd50, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      full_frame("rand", 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'($urandom),
                 (k % 2 == 1) ? 30 + k : 0);
      if (k % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
